seq_det_arbiter: RTL and testbench
==================================

# seq_det_arbiter

Round-robin controller that shares one bit-serial Moore sequence detector between two byte requesters. It accepts one byte per grant, serializes it MSB-first into a detector with a programmable pattern, and returns the per-byte hit count with a one-cycle acknowledge. It sits in front of the sequence-detector datapath and owns its sequencing, arbitration and pattern configuration.

## Interface
- PAT_LEN, 4, pattern length in bits, legal 2..8
- PAT_RST, 8'b0000_1011, pattern loaded at reset; low PAT_LEN bits used, MSB of pattern is the first bit expected
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  request per requester; held high with data stable until ack
- data0  in  8  byte from requester 0
- data1  in  8  byte from requester 1
- ack  out  2  one-cycle pulse to the served requester; byte consumed, hits valid
- gnt  out  2  one-hot, high from first SHIFT cycle through DONE
- hits  out  4  hit count for the byte just processed, valid with ack, holds until next DONE
- y  out  1  Moore detector output, high one cycle after each hit bit
- busy  out  1  high in SHIFT and DONE
- cfg_we  in  1  pattern write strobe
- cfg_pat  in  8  new pattern; low PAT_LEN bits used

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if cfg_we, latch cfg_pat and stay IDLE; any req that cycle is deferred to the next cycle. If cfg_we is low and any req is high, pick winner, latch its byte, clear window, valid-count and hit counter, then go to SHIFT.
- Arbitration: priority pointer starts at requester 0. When both req are high, the pointer side wins. After a requester is served, the pointer moves to the other requester.
- SHIFT: for 8 cycles, shift the latched byte MSB-first into the detector. bit_cnt runs 0..7, and the FSM leaves SHIFT after bit_cnt==7.
- Detector: PAT_LEN-bit window plus valid-count saturating at PAT_LEN.
  - Hit when valid-count reaches PAT_LEN (including the current bit) and window==pattern.
  - On a hit, hit counter increments and valid-count clears to 0 (non-overlapping).
- DONE: one cycle. ack[winner]=1, hits updated. Then IDLE.
- cfg_we outside IDLE is ignored.
- req dropped mid-transaction: the byte is still completed and acked.
- rst mid-operation: transaction aborted, no ack, every register returns to its reset value.

## Timing
- Reset values: ack=0, gnt=0, hits=0, y=0, busy=0, FSM=IDLE, pointer=0, pattern=PAT_RST.
- Cycle C0: req seen in IDLE.
- Cycles C1..C8: SHIFT, bit k consumed at the end of cycle C(k+1).
- Cycle C9: DONE, ack pulse.
- Latency from req sampled to ack is 9 cycles. Throughput is one byte per 10 cycles per back-to-back stream.
- y is registered. It is high in the cycle after the edge that consumed a hit bit, so a hit on bit 8 shows y=1 in C9.
- A requester that keeps req high after ack starts a new transaction in C10 if it wins arbitration.
- hits width: 4 bits. Non-overlap maximum is 8/PAT_LEN. Overlap maximum is 9−PAT_LEN. No overflow is possible.

## Configuration
- SEQDET_OVERLAP_EN defined: a hit does not clear valid-count, so windows may share bits (overlapping detection).
- SEQDET_OVERLAP_EN undefined: non-overlapping detection as in Operation.
- Everything else is identical in both builds.

## Test plan
- Non-overlap, pattern 1011:
  - req0 with data0=0xBB → ack[0] in C9, hits=2.
  - y high one cycle after bit 4 and in C9.
- Non-overlap, data0=0x5B → hits=1. With SEQDET_OVERLAP_EN, the same stimulus → hits=2.
- cfg_pat=0x0F (1111), data1=0xFF → hits=2 non-overlap, hits=5 with SEQDET_OVERLAP_EN.
- Both req high from reset with data0=0xBB and data1=0x00, both held:
  - Served in order 0, 1, 0, 1.
  - ack[0] in C9, ack[1] in C19.
  - hits 2, 0, 2, 0.
- cfg_we in the same IDLE cycle as req0 → pattern updated, gnt[0] rises one cycle later. cfg_we during SHIFT → pattern unchanged.
- rst asserted in SHIFT cycle C4 → next cycle has all outputs 0 and FSM in IDLE, and no ack is ever issued for the aborted byte.

Source files
------------

// File: rtl/seq_det_arbiter.sv
// Two-requester round-robin front end for a bit-serial Moore pattern detector.
// Define SEQDET_OVERLAP_EN to allow overlapping pattern matches.
module seq_det_arbiter #(
   parameter int         PAT_LEN = 4,
   parameter logic [7:0] PAT_RST = 8'b0000_1011
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic [1:0] ack,
   output logic [1:0] gnt,
   output logic [3:0] hits,
   output logic       y,
   output logic       busy,
   input  logic       cfg_we,
   input  logic [7:0] cfg_pat
);

   localparam int VW = $clog2(PAT_LEN + 1);
   localparam logic [VW-1:0] VMAX = VW'(PAT_LEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic               r_ptr;
   logic               r_win_id;
   logic [7:0]         r_byte;
   logic [2:0]         r_bcnt;
   logic [PAT_LEN-1:0] r_win;
   logic [PAT_LEN-1:0] r_pat;
   logic [VW-1:0]      r_vcnt;
   logic [3:0]         r_hcnt;
   logic [3:0]         r_hits;
   logic               r_y;

   logic               w_start;
   logic               w_sel;
   logic               w_shift;
   logic               w_hit;
   logic [PAT_LEN-1:0] w_win_n;
   logic [VW-1:0]      w_vinc;
   logic [VW-1:0]      w_vcnt_n;
   logic [3:0]         w_hcnt_n;
   logic               w_unused;

   assign w_unused = &{1'b0, cfg_pat};

   assign w_start = (r_state == S_IDLE) && !cfg_we && (|req);
   assign w_sel   = (req == 2'b11) ? r_ptr : req[1];
   assign w_shift = (r_state == S_SHIFT);
   assign w_win_n = {r_win[PAT_LEN-2:0], r_byte[7]};
   assign w_vinc  = (r_vcnt == VMAX) ? VMAX : r_vcnt + VW'(1);
   assign w_hit   = w_shift && (w_vinc == VMAX) && (w_win_n == r_pat);
   assign w_hcnt_n = r_hcnt + {3'b000, w_hit};

`ifdef SEQDET_OVERLAP_EN
   assign w_vcnt_n = w_vinc;
`else
   // A hit consumes its bits: the next match needs a fresh full window.
   assign w_vcnt_n = w_hit ? '0 : w_vinc;
`endif

   assign hits = r_hits;
   assign y    = r_y;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      ack    = 2'b00;
      gnt    = 2'b00;
      busy   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_start) w_next = S_SHIFT;
         end
         S_SHIFT: begin
            gnt[r_win_id] = 1'b1;
            busy          = 1'b1;
            if (r_bcnt == 3'd7) w_next = S_DONE;
         end
         S_DONE: begin
            gnt[r_win_id] = 1'b1;
            ack[r_win_id] = 1'b1;
            busy          = 1'b1;
            w_next        = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr    <= 1'b0;
         r_win_id <= 1'b0;
         r_byte   <= '0;
         r_bcnt   <= '0;
         r_win    <= '0;
         r_pat    <= PAT_RST[PAT_LEN-1:0];
         r_vcnt   <= '0;
         r_hcnt   <= '0;
         r_hits   <= '0;
         r_y      <= 1'b0;
      end else begin
         r_y <= w_hit;
         if (r_state == S_IDLE && cfg_we)
            r_pat <= cfg_pat[PAT_LEN-1:0];
         if (w_start) begin
            r_win_id <= w_sel;
            r_byte   <= w_sel ? data1 : data0;
            r_bcnt   <= '0;
            r_win    <= '0;
            r_vcnt   <= '0;
            r_hcnt   <= '0;
         end
         if (w_shift) begin
            r_byte <= {r_byte[6:0], 1'b0};
            r_bcnt <= r_bcnt + 3'd1;
            r_win  <= w_win_n;
            r_vcnt <= w_vcnt_n;
            r_hcnt <= w_hcnt_n;
            if (r_bcnt == 3'd7) r_hits <= w_hcnt_n;
         end
         if (r_state == S_DONE)
            r_ptr <= ~r_win_id;
      end
   end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Randomised, model-checked bench for seq_det_arbiter.
// Expected hit counts come from a sliding-window pattern scan of each byte.
module tb_seq_det_arbiter;

   localparam int PL = 4;
`ifdef SEQDET_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [7:0] data0;
   logic [7:0] data1;
   logic [1:0] ack;
   logic [1:0] gnt;
   logic [3:0] hits;
   logic       y;
   logic       busy;
   logic       cfg_we;
   logic [7:0] cfg_pat;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] m_pat;

   seq_det_arbiter #(.PAT_LEN(PL), .PAT_RST(8'h0B)) dut (
      .clk(clk), .rst(rst), .req(req),
      .data0(data0), .data1(data1),
      .ack(ack), .gnt(gnt), .hits(hits),
      .y(y), .busy(busy),
      .cfg_we(cfg_we), .cfg_pat(cfg_pat)
   );

   always #5 clk = ~clk;

   // Scan the byte MSB-first; hm[k] marks a match ending on bit k.
   function automatic void model(input logic [7:0] b,
                                 input logic [7:0] pat,
                                 output logic [3:0] cnt,
                                 output logic [7:0] hm);
      int last;
      bit m;
      cnt  = 0;
      hm   = 0;
      last = -1;
      for (int k = PL - 1; k < 8; k++) begin
         m = 1'b1;
         for (int j = 0; j < PL; j++)
            if (b[7 - (k - PL + 1 + j)] != pat[PL - 1 - j]) m = 1'b0;
         if (m && (OVL || (k - PL + 1 > last))) begin
            cnt   = cnt + 4'd1;
            hm[k] = 1'b1;
            last  = k;
         end
      end
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_idle(input logic [7:0] p);
      cfg_pat = p;
      cfg_we  = 1'b1;
      tick;
      cfg_we  = 1'b0;
   endtask

   // One transaction from an IDLE cycle (C0) to the IDLE cycle after ack.
   task automatic run_txn(input int r, input logic [7:0] b,
                          input int cfg_at,
                          output int ack_c, output logic [3:0] h,
                          output logic [7:0] yt,
                          output bit gnt_ok, output bit idle_ok);
      ack_c  = -1;
      h      = 4'hF;
      yt     = 8'h00;
      gnt_ok = 1'b1;
      if (r == 0) data0 = b;
      else        data1 = b;
      req[r] = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         tick;
         cfg_we = (c == cfg_at);
         if (c >= 2 && c <= 9) yt[c-2] = y;
         if (c <= 9 && !(gnt == (2'b01 << r) && busy)) gnt_ok = 1'b0;
         if (ack[r]) begin
            ack_c = c;
            h     = hits;
            break;
         end
      end
      cfg_we = 1'b0;
      req[r] = 1'b0;
      tick;
      idle_ok = !busy && ack == 2'b00 && gnt == 2'b00 && !y;
   endtask

   task automatic test_reset;
      rst = 1'b1; req = 2'b00; cfg_we = 1'b0;
      data0 = 8'h00; data1 = 8'h00; cfg_pat = 8'h00;
      tick; tick;
      n_cmp++;
      if ({ack, gnt, hits, y, busy} !== 10'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want 0", {ack, gnt, hits, y, busy});
      end
      rst = 1'b0;
      tick;
      m_pat = 8'h0B;
   endtask

   task automatic test_basic;
      int ac; logic [3:0] h, eh; logic [7:0] yt, ehm; bit go, io;
      model(8'hBB, m_pat, eh, ehm);
      run_txn(0, 8'hBB, -1, ac, h, yt, go, io);
      n_cmp++;
      if (ac !== 9) begin n_err++; $display("FAIL bb_ack_cycle: got %0d want 9", ac); end
      n_cmp++;
      if (h !== eh || h !== 4'd2) begin n_err++; $display("FAIL bb_hits: got %0d want %0d", h, eh); end
      n_cmp++;
      if (yt !== ehm) begin n_err++; $display("FAIL bb_y_trace: got %b want %b", yt, ehm); end
      n_cmp++;
      if (!go) begin n_err++; $display("FAIL bb_gnt_busy: got bad want gnt0+busy in C1..C9"); end
      n_cmp++;
      if (!io) begin n_err++; $display("FAIL bb_idle_after: got active want idle"); end
   endtask

   task automatic test_5b;
      int ac; logic [3:0] h, eh; logic [7:0] yt, ehm; bit go, io;
      model(8'h5B, m_pat, eh, ehm);
      run_txn(0, 8'h5B, -1, ac, h, yt, go, io);
      n_cmp++;
      if (h !== eh || h !== (OVL ? 4'd2 : 4'd1)) begin
         n_err++; $display("FAIL 5b_hits: got %0d want %0d", h, eh);
      end
      n_cmp++;
      if (yt !== ehm) begin n_err++; $display("FAIL 5b_y_trace: got %b want %b", yt, ehm); end
   endtask

   task automatic test_cfg_ff;
      int ac; logic [3:0] h, eh; logic [7:0] yt, ehm; bit go, io;
      cfg_idle(8'h0F);
      m_pat = 8'h0F;
      model(8'hFF, m_pat, eh, ehm);
      run_txn(1, 8'hFF, -1, ac, h, yt, go, io);
      n_cmp++;
      if (h !== eh || h !== (OVL ? 4'd5 : 4'd2)) begin
         n_err++; $display("FAIL ff_hits: got %0d want %0d", h, eh);
      end
      n_cmp++;
      if (ac !== 9 || !go) begin n_err++; $display("FAIL ff_req1_timing: got ack C%0d want C9", ac); end
   endtask

   task automatic test_cfg_same_cycle;
      int ac; logic [3:0] h, eh; logic [7:0] yt, ehm; bit go, io;
      cfg_pat = 8'h0B; cfg_we = 1'b1;
      data0 = 8'hBB; req[0] = 1'b1;
      tick;
      cfg_we = 1'b0;
      n_cmp++;
      if (gnt !== 2'b00 || busy !== 1'b0) begin
         n_err++; $display("FAIL cfg_defer: got gnt=%b busy=%b want 00/0", gnt, busy);
      end
      m_pat = 8'h0B;
      model(8'hBB, m_pat, eh, ehm);
      run_txn(0, 8'hBB, -1, ac, h, yt, go, io);
      n_cmp++;
      if (ac !== 9 || !go) begin n_err++; $display("FAIL cfg_defer_start: got ack C%0d want C9", ac); end
      n_cmp++;
      if (h !== eh) begin n_err++; $display("FAIL cfg_new_pat_hits: got %0d want %0d", h, eh); end
   endtask

   task automatic test_cfg_in_shift;
      int ac; logic [3:0] h, eh; logic [7:0] yt, ehm; bit go, io;
      cfg_pat = 8'h0F;
      model(8'hFF, m_pat, eh, ehm);
      run_txn(0, 8'hFF, 2, ac, h, yt, go, io);
      n_cmp++;
      if (h !== eh) begin n_err++; $display("FAIL cfg_shift_hits: got %0d want %0d", h, eh); end
      model(8'hBB, m_pat, eh, ehm);
      run_txn(0, 8'hBB, -1, ac, h, yt, go, io);
      n_cmp++;
      if (h !== eh || h !== 4'd2) begin
         n_err++; $display("FAIL cfg_shift_pat_kept: got %0d want %0d", h, eh);
      end
   endtask

   task automatic test_rst_mid;
      int ac; logic [3:0] h, eh; logic [7:0] yt, ehm; bit go, io;
      bit seen;
      cfg_idle(8'h0F);
      data0 = 8'hBB; req[0] = 1'b1;
      tick; tick; tick; tick;
      rst = 1'b1;
      tick;
      n_cmp++;
      if ({ack, gnt, hits, y, busy} !== 10'd0) begin
         n_err++; $display("FAIL rst_mid_outputs: got %b want 0", {ack, gnt, hits, y, busy});
      end
      rst = 1'b0; req = 2'b00;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (ack != 2'b00) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL rst_mid_no_ack: got ack want none"); end
      m_pat = 8'h0B;
      model(8'hBB, m_pat, eh, ehm);
      run_txn(0, 8'hBB, -1, ac, h, yt, go, io);
      n_cmp++;
      if (h !== eh) begin n_err++; $display("FAIL rst_pat_restored: got %0d want %0d", h, eh); end
   endtask

   task automatic test_back_to_back;
      int         cyc_q[$];
      logic [1:0] ack_q[$];
      logic [3:0] hit_q[$];
      logic [3:0] e0, e1, eh;
      logic [7:0] hm;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      m_pat = 8'h0B;
      model(8'hBB, m_pat, e0, hm);
      model(8'h00, m_pat, e1, hm);
      data0 = 8'hBB; data1 = 8'h00; req = 2'b11;
      for (int c = 1; c <= 60; c++) begin
         tick;
         if (ack != 2'b00) begin
            cyc_q.push_back(c);
            ack_q.push_back(ack);
            hit_q.push_back(hits);
            if (cyc_q.size() == 4) break;
         end
      end
      req = 2'b00;
      tick;
      n_cmp++;
      if (cyc_q.size() != 4) begin
         n_err++; $display("FAIL rr_ack_count: got %0d want 4", cyc_q.size());
      end
      for (int i = 0; i < cyc_q.size(); i++) begin
         eh = (i % 2 == 0) ? e0 : e1;
         n_cmp++;
         if (cyc_q[i] != 9 + 10 * i || ack_q[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)
             || hit_q[i] !== eh) begin
            n_err++;
            $display("FAIL rr_ack%0d: got C%0d ack=%b hits=%0d want C%0d ack=%b hits=%0d",
                     i, cyc_q[i], ack_q[i], hit_q[i], 9 + 10 * i,
                     (i % 2 == 0) ? 2'b01 : 2'b10, eh);
         end
      end
   endtask

   task automatic test_random;
      int ac, r; logic [3:0] h, eh; logic [7:0] yt, ehm, b; bit go, io;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            m_pat = 8'($urandom);
            cfg_idle(m_pat);
         end
         r = $urandom_range(0, 1);
         b = 8'($urandom);
         model(b, m_pat, eh, ehm);
         run_txn(r, b, -1, ac, h, yt, go, io);
         n_cmp++;
         if (ac !== 9 || h !== eh || yt !== ehm || !go || !io) begin
            n_err++;
            $display("FAIL rand%0d: req%0d byte=%h pat=%h got C%0d hits=%0d y=%b want C9 hits=%0d y=%b",
                     i, r, b, m_pat[PL-1:0], ac, h, yt, eh, ehm);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_5b;
      test_cfg_ff;
      test_cfg_same_cycle;
      test_cfg_in_shift;
      test_rst_mid;
      test_back_to_back;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
